// File: rtl/subbytes_scheduler.sv
// Round-robin job scheduler for one shared 32-bit SubBytes lane.
// State jobs run as four column beats; key SubWord jobs run as a single beat.
module subbytes_scheduler #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         st_valid_i,
    output logic         st_ready_o,
    input  logic [127:0] st_data_i,
    output logic         st_done_o,
    output logic [127:0] st_result_o,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [31:0]  key_word_i,
    output logic         key_done_o,
    output logic [31:0]  key_result_o,
    output logic [31:0]  sb_in_o,
    input  logic [31:0]  sb_out_i,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_RUN  = 2'd1,
        KEY_RUN = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pri_q, pri_d;
    logic [127:0] st_buf_q, st_buf_d;
    logic [31:0]  key_buf_q, key_buf_d;
    logic [127:0] st_result_q, st_result_d;
    logic [31:0]  key_result_q, key_result_d;
    logic         st_done_q, st_done_d;
    logic         key_done_q, key_done_d;
    logic         grant_st, grant_key;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            pri_q        <= KEY_FIRST;
            st_buf_q     <= '0;
            key_buf_q    <= '0;
            st_result_q  <= '0;
            key_result_q <= '0;
            st_done_q    <= 1'b0;
            key_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pri_q        <= pri_d;
            st_buf_q     <= st_buf_d;
            key_buf_q    <= key_buf_d;
            st_result_q  <= st_result_d;
            key_result_q <= key_result_d;
            st_done_q    <= st_done_d;
            key_done_q   <= key_done_d;
        end
    end

    // pri_q = 1 means the key requester wins the next simultaneous request
    assign grant_st  = st_valid_i & (~key_valid_i | ~pri_q);
    assign grant_key = key_valid_i & (~st_valid_i | pri_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pri_d        = pri_q;
        st_buf_d     = st_buf_q;
        key_buf_d    = key_buf_q;
        st_result_d  = st_result_q;
        key_result_d = key_result_q;
        st_done_d    = 1'b0;
        key_done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_st) begin
                    st_buf_d = st_data_i;
                    cnt_d    = 2'd0;
                    pri_d    = 1'b1;
                    state_d  = ST_RUN;
                end else if (grant_key) begin
                    key_buf_d = key_word_i;
                    pri_d     = 1'b0;
                    state_d   = KEY_RUN;
                end
            end
            ST_RUN: begin
                unique case (cnt_q)
                    2'd0: st_result_d[127:96] = sb_out_i;
                    2'd1: st_result_d[95:64]  = sb_out_i;
                    2'd2: st_result_d[63:32]  = sb_out_i;
                    2'd3: st_result_d[31:0]   = sb_out_i;
                    default: ;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = IDLE;
                    st_done_d = 1'b1;
                end
            end
            KEY_RUN: begin
                key_result_d = sb_out_i;
                key_done_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sb_in_o = 32'h0;
        unique case (state_q)
            ST_RUN: begin
                unique case (cnt_q)
                    2'd0: sb_in_o = st_buf_q[127:96];
                    2'd1: sb_in_o = st_buf_q[95:64];
                    2'd2: sb_in_o = st_buf_q[63:32];
                    2'd3: sb_in_o = st_buf_q[31:0];
                    default: sb_in_o = 32'h0;
                endcase
            end
            KEY_RUN: sb_in_o = key_buf_q;
            default: sb_in_o = 32'h0;
        endcase
        // readies stay low while reset is held, even though the FSM already sits in IDLE
        st_ready_o  = (state_q == IDLE) & ~rst_i;
        key_ready_o = (state_q == IDLE) & ~rst_i;
        busy_o      = (state_q == ST_RUN) | (state_q == KEY_RUN);
    end

    assign st_done_o    = st_done_q;
    assign key_done_o   = key_done_q;
    assign st_result_o  = st_result_q;
    assign key_result_o = key_result_q;

endmodule
